// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the parametrised code lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_UNLOCK,
    S_FAIL,
    S_LOCKOUT
  } state_e;

  localparam int unsigned KEY_RED   = 0;
  localparam int unsigned KEY_GREEN = 1;
  localparam int unsigned KEY_BLUE  = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/code_lock_fsm_key_event_enc.sv
// Key edge detector: one press event per key-down, encoded to a symbol index.
module key_event_enc
  import code_lock_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 3,
  parameter int unsigned SYM_W    = max1(clog2(NUM_KEYS))
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic                press_o,
  output logic [SYM_W-1:0]    sym_o,
  output logic                invalid_o
);

  logic [NUM_KEYS-1:0] key_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) key_prev_q <= '0;
    else       key_prev_q <= keys_i;
  end

  assign press_o = (|keys_i) && !(|key_prev_q);

  // Anything other than exactly one set bit is flagged so it can never match.
  always_comb begin
    int unsigned ones;
    ones  = 0;
    sym_o = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys_i[i]) begin
        ones  = ones + 1;
        sym_o = SYM_W'(i);
      end
    end
    invalid_o = (ones != 1);
  end

endmodule

// File: rtl/code_lock_fsm.sv
// Parametrised key-sequence lock with timeout, failure counting and lockout.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 3,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*max1(clog2(NUM_KEYS))-1:0] DEFAULT_CODE = 8'h18,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                                      Clk,
  input  logic                                      Rst,
  input  logic                                      Start,
  input  logic [NUM_KEYS-1:0]                       Keys,
  input  logic                                      ProgEn,
  input  logic [CODE_LEN*max1(clog2(NUM_KEYS))-1:0] ProgCode,
  output logic                                      U,
  output logic                                      Fail,
  output logic                                      Armed,
  output logic                                      Locked
);

  localparam int unsigned SYM_W  = max1(clog2(NUM_KEYS));
  localparam int unsigned CODE_W = CODE_LEN * SYM_W;
  localparam int unsigned IDX_W  = max1(clog2(CODE_LEN));
  localparam int unsigned TMR_W  = max1(clog2(TIMEOUT_CYCLES + 1));
  localparam int unsigned FC_W   = max1(clog2(MAX_FAILS + 1));
  localparam int unsigned LO_W   = max1(clog2(LOCKOUT_CYCLES));

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [TMR_W-1:0]  tmr_q,   tmr_d;
  logic [FC_W-1:0]   fc_q,    fc_d;
  logic [LO_W-1:0]   lo_q,    lo_d;
  logic [CODE_W-1:0] code_q,  code_d;

  logic             press;
  logic             invalid;
  logic [SYM_W-1:0] sym;
  logic [SYM_W-1:0] code_sym;
  logic             hit;

  key_event_enc #(
    .NUM_KEYS(NUM_KEYS),
    .SYM_W   (SYM_W)
  ) u_key_event_enc (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .keys_i   (Keys),
    .press_o  (press),
    .sym_o    (sym),
    .invalid_o(invalid)
  );

  always_comb begin
    code_sym = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) code_sym = code_q[i*SYM_W +: SYM_W];
    end
  end

  // sym is always below NUM_KEYS, so out-of-range code symbols never compare equal.
  assign hit = press && !invalid && (sym == code_sym);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      fc_q    <= '0;
      lo_q    <= '0;
      code_q  <= DEFAULT_CODE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      fc_q    <= fc_d;
      lo_q    <= lo_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    fc_d    = fc_q;
    lo_d    = lo_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (ProgEn) begin
          code_d = ProgCode;
        end else if (Start) begin
          state_d = S_ENTER;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      S_ENTER: begin
        if (Start) begin
          idx_d = '0;
          tmr_d = '0;
        end else if (press) begin
          if (!hit) begin
            state_d = S_FAIL;
          end else if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            state_d = S_UNLOCK;
          end else begin
            idx_d = idx_q + 1'b1;
            tmr_d = '0;
          end
        end else begin
          if (tmr_q != '1) tmr_d = tmr_q + 1'b1;
          if (TIMEOUT_CYCLES != 0 && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) state_d = S_FAIL;
        end
      end
      S_UNLOCK: begin
        fc_d    = '0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        if (fc_q != FC_W'(MAX_FAILS)) fc_d = fc_q + 1'b1;
        if (32'(fc_q) + 32'd1 >= MAX_FAILS) begin
          state_d = S_LOCKOUT;
          lo_d    = LO_W'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lo_q == '0) begin
          fc_d    = '0;
          state_d = S_IDLE;
        end else begin
          lo_d = lo_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign U      = (state_q == S_UNLOCK);
  assign Fail   = (state_q == S_FAIL);
  assign Armed  = (state_q == S_ENTER);
  assign Locked = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm against a cycle-level behavioural model.
module tb_code_lock_fsm;

  localparam int NK = 3;
  localparam int CL = 4;
  localparam int TO = 64;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam logic [7:0] DEF = 8'h18;
  localparam logic [2:0] KR = 3'b001;
  localparam logic [2:0] KG = 3'b010;
  localparam logic [2:0] KB = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prog_en = 1'b0;
  logic [2:0] keys = '0;
  logic [7:0] prog_code = '0;
  logic       u, fail, armed, locked;

  code_lock_fsm #(
    .NUM_KEYS      (NK),
    .CODE_LEN      (CL),
    .DEFAULT_CODE  (DEF),
    .TIMEOUT_CYCLES(TO),
    .MAX_FAILS     (MF),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .Clk     (clk),
    .Rst     (rst),
    .Start   (start),
    .Keys    (keys),
    .ProgEn  (prog_en),
    .ProgCode(prog_code),
    .U       (u),
    .Fail    (fail),
    .Armed   (armed),
    .Locked  (locked)
  );

  always #5 clk = ~clk;

  // Behavioural model: entry progress, idle count, pending pulses, lockout cycles left.
  int         m_code[CL];
  bit         m_armed, m_pu, m_pf;
  int         m_pos, m_idle, m_fails, m_lock;
  logic [2:0] m_prev;

  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic int key_sym(input logic [2:0] k);
    if ($countones(k) != 1) return -1;
    for (int i = 0; i < NK; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic load_code(input logic [7:0] c);
    for (int i = 0; i < CL; i++) m_code[i] = int'(c[2*i +: 2]);
  endtask

  task automatic model_step(input bit r, input bit s, input bit pe,
                            input logic [7:0] pc, input logic [2:0] k);
    bit pr;
    int sy;
    if (r) begin
      m_armed = 0; m_pu = 0; m_pf = 0;
      m_pos = 0; m_idle = 0; m_fails = 0; m_lock = 0;
      m_prev = '0;
      load_code(DEF);
      return;
    end
    pr = (k != 0) && (m_prev == 0);
    m_prev = k;
    sy = key_sym(k);
    if (m_pu) begin
      m_pu = 0;
      m_fails = 0;
    end else if (m_pf) begin
      m_pf = 0;
      if (m_fails < MF) m_fails++;
      if (m_fails >= MF) m_lock = LC;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_armed) begin
      if (s) begin
        m_pos = 0; m_idle = 0;
      end else if (pr) begin
        if (sy >= 0 && sy == m_code[m_pos]) begin
          if (m_pos == CL - 1) begin m_armed = 0; m_pu = 1; end
          else begin m_pos++; m_idle = 0; end
        end else begin
          m_armed = 0; m_pf = 1;
        end
      end else begin
        m_idle++;
        if (TO != 0 && m_idle == TO) begin m_armed = 0; m_pf = 1; end
      end
    end else begin
      if (pe) load_code(pc);
      else if (s) begin m_armed = 1; m_pos = 0; m_idle = 0; end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit pe,
                      input logic [7:0] pc, input logic [2:0] k);
    @(negedge clk);
    rst = r; start = s; prog_en = pe; prog_code = pc; keys = k;
    model_step(r, s, pe, pc, k);
    exp_q.push_back({m_pu, m_pf, m_armed, (m_lock > 0)});
  endtask

  task automatic run(input bit s, input logic [2:0] k);
    step(1'b0, s, 1'b0, 8'h00, k);
  endtask

  task automatic press(input logic [2:0] k);
    run(1'b0, k);
    run(1'b0, 3'b000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run(1'b0, 3'b000);
  endtask

  task automatic prog(input logic [7:0] c);
    step(1'b0, 1'b0, 1'b1, c, 3'b000);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'b000);
  endtask

  task automatic enter_model_code();
    run(1'b1, 3'b000);
    for (int i = 0; i < CL; i++) press((m_code[i] < NK) ? 3'(1 << m_code[i]) : 3'b011);
  endtask

  // Monitor: compares every presented output vector against the scoreboard.
  initial begin
    logic [3:0] e, got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {u, fail, armed, locked};
        total++;
        cyc++;
        if (got !== e) begin
          bad++;
          $display("FAIL outs cyc=%0d got U,Fail,Armed,Locked=%b expected=%b", cyc, got, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] cur_k;
    int r;
    cur_k = '0;

    do_reset();
    do_reset();

    // Default code R,B,G,R
    run(1'b1, 3'b000);
    press(KR); press(KB); press(KG); press(KR);
    idle(3);

    // Three wrong entries, then inputs ignored through lockout, then unlock
    for (int n = 0; n < 3; n++) begin
      run(1'b1, 3'b000);
      press(KR); press(KG);
      idle(2);
    end
    run(1'b1, KR); run(1'b0, KB); run(1'b1, 3'b000); run(1'b0, 3'b000);
    prog(8'h00);
    idle(16);
    enter_model_code();
    idle(2);

    // Held key counts once; chord fails
    run(1'b1, 3'b000);
    for (int i = 0; i < 10; i++) run(1'b0, KR);
    run(1'b0, 3'b000);
    press(KB); press(KG); press(KR);
    idle(2);
    run(1'b1, 3'b000);
    press(KR | KB);
    idle(2);

    // Reprogramming, old code rejected, ProgEn ignored while entering
    prog(8'h00);
    run(1'b1, 3'b000);
    for (int i = 0; i < 4; i++) press(KR);
    idle(2);
    run(1'b1, 3'b000);
    press(KR); press(KB);
    idle(2);
    run(1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b1, DEF, 3'b000);
    for (int i = 0; i < 4; i++) press(KR);
    idle(2);

    // Timeout, and a press at the last idle cycle before it
    run(1'b1, 3'b000);
    press(KR);
    idle(70);
    run(1'b1, 3'b000);
    run(1'b0, KR);
    idle(62);
    run(1'b0, KR);
    idle(66);

    // Reset mid-entry drops the programmed code
    do_reset();
    prog(8'h00);
    run(1'b1, 3'b000);
    press(KR); press(KR); press(KR);
    do_reset();
    idle(1);
    run(1'b1, 3'b000);
    press(KR); press(KB); press(KG); press(KR);
    idle(2);

    // Reset mid-lockout clears the fail count
    for (int n = 0; n < 3; n++) begin
      run(1'b1, 3'b000);
      press(KG);
      idle(1);
    end
    idle(5);
    do_reset();
    idle(2);
    run(1'b1, 3'b000);
    press(KG);
    idle(3);
    enter_model_code();
    idle(2);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 4) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1,
             ($urandom_range(0, 1) != 0) ? DEF : 8'($urandom_range(0, 255)), cur_k);
      end else if (r < 9) begin
        run(1'b1, cur_k);
      end else if (r < 12) begin
        enter_model_code();
        cur_k = '0;
      end else begin
        if ($urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 5))
            0, 1: cur_k = 3'b000;
            2:    cur_k = KR;
            3:    cur_k = KG;
            4:    cur_k = KB;
            default: cur_k = 3'($urandom_range(0, 7));
          endcase
        end
        run(1'b0, cur_k);
      end
    end
    idle(2);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
